// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: redirect/prediction inputs, I-mem address and decode-side metadata.
// FETCH_PERF_EN adds the fetchCount/redirectCount performance counters.
interface fetch_pc_gen_if #(
  parameter int unsigned WIDTH = 31
);
  logic             mispredict;
  logic [WIDTH:0]   mispredictPC;
  logic             jump;
  logic [WIDTH:0]   jumpPC;
  logic             btbHit;
  logic [WIDTH:0]   btbPC;
  logic             decodeReady;
  logic [WIDTH:0]   rAddress;
  logic             fetchValid;
  logic [WIDTH:0]   fetchPC;
  logic [WIDTH:0]   seqPC;
  logic             predTaken;
`ifdef FETCH_PERF_EN
  logic [31:0]      fetchCount;
  logic [31:0]      redirectCount;

  // master: the PC generator; slave: the pipeline around it
  modport master (
    input  mispredict, mispredictPC, jump, jumpPC, btbHit, btbPC, decodeReady,
    output rAddress, fetchValid, fetchPC, seqPC, predTaken, fetchCount, redirectCount
  );
  modport slave (
    output mispredict, mispredictPC, jump, jumpPC, btbHit, btbPC, decodeReady,
    input  rAddress, fetchValid, fetchPC, seqPC, predTaken, fetchCount, redirectCount
  );
`else
  modport master (
    input  mispredict, mispredictPC, jump, jumpPC, btbHit, btbPC, decodeReady,
    output rAddress, fetchValid, fetchPC, seqPC, predTaken
  );
  modport slave (
    output mispredict, mispredictPC, jump, jumpPC, btbHit, btbPC, decodeReady,
    input  rAddress, fetchValid, fetchPC, seqPC, predTaken
  );
`endif
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: priority next-PC select, I-mem address, metadata aligned to I-mem data.
// Optional performance counters enabled by defining FETCH_PERF_EN.
module fetch_pc_gen #(
  parameter int unsigned    WIDTH    = 31,
  parameter logic [WIDTH:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          resetN,
  fetch_pc_gen_if.master bus
);
  localparam int unsigned PC_W = WIDTH + 1;

  logic [WIDTH:0] r_pcReg;
  logic           r_fetchValid;
  logic [WIDTH:0] r_fetchPC;
  logic [WIDTH:0] r_seqPC;
  logic           r_predTaken;

  logic [WIDTH:0] w_pcNext;
  logic           w_fetchValidNext;
  logic [WIDTH:0] w_fetchPCNext;
  logic [WIDTH:0] w_seqPCNext;
  logic           w_predTakenNext;

  logic           w_stall;
  logic           w_accept;
  logic           w_jumpTaken;
  logic           w_redirect;
  logic [WIDTH:0] w_pcPlus4;
  logic [WIDTH:0] w_selPC;

  assign w_stall     = r_fetchValid & ~bus.decodeReady;
  assign w_accept    = r_fetchValid & bus.decodeReady;
  assign w_jumpTaken = bus.jump & w_accept;
  assign w_redirect  = bus.mispredict | w_jumpTaken;
  assign w_pcPlus4   = r_pcReg + PC_W'(4);

  // A stalled instruction is re-read so the memory output stays stable
  assign w_selPC      = w_stall ? r_fetchPC : r_pcReg;
  assign bus.rAddress = {2'b00, w_selPC[WIDTH:2]};

  // Next-PC priority: mispredict, accepted jump, stall hold, BTB target, sequential
  always_comb begin
    w_pcNext         = r_pcReg;
    w_fetchValidNext = r_fetchValid;
    w_fetchPCNext    = r_fetchPC;
    w_seqPCNext      = r_seqPC;
    w_predTakenNext  = r_predTaken;
    if (bus.mispredict) begin
      w_pcNext         = bus.mispredictPC;
      w_fetchValidNext = 1'b0;
    end else if (w_jumpTaken) begin
      w_pcNext         = bus.jumpPC;
      w_fetchValidNext = 1'b0;
    end else if (!w_stall) begin
      w_pcNext         = bus.btbHit ? bus.btbPC : w_pcPlus4;
      w_fetchValidNext = 1'b1;
      w_fetchPCNext    = r_pcReg;
      w_seqPCNext      = w_pcPlus4;
      w_predTakenNext  = bus.btbHit;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_pcReg      <= RESET_PC;
      r_fetchValid <= 1'b0;
      r_fetchPC    <= '0;
      r_seqPC      <= '0;
      r_predTaken  <= 1'b0;
    end else begin
      r_pcReg      <= w_pcNext;
      r_fetchValid <= w_fetchValidNext;
      r_fetchPC    <= w_fetchPCNext;
      r_seqPC      <= w_seqPCNext;
      r_predTaken  <= w_predTakenNext;
    end
  end

  assign bus.fetchValid = r_fetchValid;
  assign bus.fetchPC    = r_fetchPC;
  assign bus.seqPC      = r_seqPC;
  assign bus.predTaken  = r_predTaken;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetchCount;
  logic [31:0] r_redirectCount;

  // Both counters wrap silently at 2^32
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_fetchCount    <= '0;
      r_redirectCount <= '0;
    end else begin
      if (w_accept)   r_fetchCount    <= r_fetchCount + 32'd1;
      if (w_redirect) r_redirectCount <= r_redirectCount + 32'd1;
    end
  end

  assign bus.fetchCount    = r_fetchCount;
  assign bus.redirectCount = r_redirectCount;
`else
  logic w_unusedRedirect;
  assign w_unusedRedirect = w_redirect;
`endif
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed vector table, hand sequences, random vs reference model.
module tb_fetch_pc_gen;
  logic clk;
  logic resetN;

  fetch_pc_gen_if #(.WIDTH(31)) bus ();

  fetch_pc_gen #(.WIDTH(31), .RESET_PC(32'h0000_0000)) u_dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        mp;
    logic [31:0] mpc;
    logic        j;
    logic [31:0] jpc;
    logic        bh;
    logic [31:0] bpc;
    logic        dr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] exp_raddr;
    logic        exp_valid;
    logic [31:0] exp_fpc;
    logic [31:0] exp_spc;
    logic        exp_pred;
  } vec_t;

  int n_chk;
  int n_fail;

  // Reference model: architectural view of the fetch stage
  logic        m_known;
  logic [31:0] m_pc;
  logic        m_v;
  logic [31:0] m_fpc;
  logic [31:0] m_spc;
  logic        m_pred;
  logic [31:0] m_fcnt;
  logic [31:0] m_rcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mks(input logic mp, input logic [31:0] mpc, input logic j,
                                input logic [31:0] jpc, input logic bh, input logic [31:0] bpc,
                                input logic dr);
    stim_t s;
    s.rstn = 1'b1; s.mp = mp; s.mpc = mpc; s.j = j; s.jpc = jpc;
    s.bh = bh; s.bpc = bpc; s.dr = dr;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic [31:0] ra, input logic v,
                               input logic [31:0] fpc, input logic [31:0] spc, input logic pred);
    vec_t r;
    r.s = s; r.exp_raddr = ra; r.exp_valid = v; r.exp_fpc = fpc; r.exp_spc = spc; r.exp_pred = pred;
    return r;
  endfunction

  // One clock: drive, check rAddress mid-cycle, clock, advance model, check registered outputs
  task automatic run_cycle(input stim_t s);
    logic [31:0] ra_exp;
    logic        accept;
    resetN           = s.rstn;
    bus.mispredict   = s.mp;
    bus.mispredictPC = s.mpc;
    bus.jump         = s.j;
    bus.jumpPC       = s.jpc;
    bus.btbHit       = s.bh;
    bus.btbPC        = s.bpc;
    bus.decodeReady  = s.dr;
    @(negedge clk);
    ra_exp = ((m_v && !s.dr) ? m_fpc : m_pc) >> 2;
    if (m_known) chk("rAddress", bus.rAddress, ra_exp);
    @(posedge clk);
    accept = m_v && s.dr;
    if (!s.rstn) begin
      m_pc = 32'h0; m_v = 1'b0; m_fpc = 32'h0; m_spc = 32'h0; m_pred = 1'b0;
      m_fcnt = 32'h0; m_rcnt = 32'h0; m_known = 1'b1;
    end else begin
      if (accept) m_fcnt = m_fcnt + 1;
      if (s.mp || (s.j && accept)) m_rcnt = m_rcnt + 1;
      if (s.mp) begin
        m_pc = s.mpc; m_v = 1'b0;
      end else if (s.j && accept) begin
        m_pc = s.jpc; m_v = 1'b0;
      end else if (!(m_v && !s.dr)) begin
        m_fpc = m_pc; m_spc = m_pc + 4; m_pred = s.bh; m_v = 1'b1;
        m_pc = s.bh ? s.bpc : m_pc + 4;
      end
    end
    #1;
    chk("fetchValid", bus.fetchValid, m_v);
    chk("fetchPC",    bus.fetchPC,    m_fpc);
    chk("seqPC",      bus.seqPC,      m_spc);
    chk("predTaken",  bus.predTaken,  m_pred);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rstn = ($urandom_range(0, 255) != 0);
    s.mp   = ($urandom_range(0, 15) == 0);
    s.mpc  = ($urandom_range(0, 7) == 0) ? 32'($urandom()) : (32'($urandom()) & 32'hFFFF_FFFC);
    s.j    = ($urandom_range(0, 7) == 0);
    s.jpc  = 32'($urandom()) & 32'hFFFF_FFFC;
    s.bh   = ($urandom_range(0, 3) == 0);
    s.bpc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : (32'($urandom()) & 32'hFFFF_FFFC);
    s.dr   = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  vec_t  vecs[21];
  stim_t idle;
  stim_t rst;

  initial begin
    n_chk = 0; n_fail = 0; m_known = 1'b0;
    m_pc = '0; m_v = 1'b0; m_fpc = '0; m_spc = '0; m_pred = 1'b0; m_fcnt = '0; m_rcnt = '0;

    idle = mks(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    rst  = idle; rst.rstn = 1'b0;

    vecs[0]  = mkv(idle, 32'h0, 1'b1, 32'h0,  32'h4,  1'b0);
    vecs[1]  = mkv(idle, 32'h1, 1'b1, 32'h4,  32'h8,  1'b0);
    vecs[2]  = mkv(mks(0, 0, 0, 0, 1, 32'h40, 1), 32'h2, 1'b1, 32'h8, 32'hC, 1'b1);
    vecs[3]  = mkv(idle, 32'h10, 1'b1, 32'h40, 32'h44, 1'b0);
    vecs[4]  = mkv(idle, 32'h11, 1'b1, 32'h44, 32'h48, 1'b0);
    vecs[5]  = mkv(mks(1, 32'h8, 0, 0, 0, 0, 1), 32'h12, 1'b0, 32'h44, 32'h48, 1'b0);
    vecs[6]  = mkv(idle, 32'h2, 1'b1, 32'h8,  32'hC,  1'b0);
    vecs[7]  = mkv(idle, 32'h3, 1'b1, 32'hC,  32'h10, 1'b0);
    vecs[8]  = mkv(mks(0, 0, 0, 0, 0, 0, 0), 32'h3, 1'b1, 32'hC, 32'h10, 1'b0);
    vecs[9]  = mkv(mks(0, 0, 0, 0, 1, 32'h90, 0), 32'h3, 1'b1, 32'hC, 32'h10, 1'b0);
    vecs[10] = mkv(mks(0, 0, 0, 0, 0, 0, 0), 32'h3, 1'b1, 32'hC, 32'h10, 1'b0);
    vecs[11] = mkv(idle, 32'h4, 1'b1, 32'h10, 32'h14, 1'b0);
    vecs[12] = mkv(mks(1, 32'h80, 1, 32'h200, 1, 32'h300, 0), 32'h4, 1'b0, 32'h10, 32'h14, 1'b0);
    vecs[13] = mkv(idle, 32'h20, 1'b1, 32'h80, 32'h84, 1'b0);
    vecs[14] = mkv(mks(0, 0, 1, 32'h20, 1, 32'h300, 1), 32'h21, 1'b0, 32'h80, 32'h84, 1'b0);
    vecs[15] = mkv(idle, 32'h8, 1'b1, 32'h20, 32'h24, 1'b0);
    vecs[16] = mkv(mks(0, 0, 1, 32'h500, 0, 0, 0), 32'h8, 1'b1, 32'h20, 32'h24, 1'b0);
    vecs[17] = mkv(idle, 32'h9, 1'b1, 32'h24, 32'h28, 1'b0);
    vecs[18] = mkv(mks(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1), 32'hA, 1'b0, 32'h24, 32'h28, 1'b0);
    vecs[19] = mkv(idle, 32'h3FFF_FFFF, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0);
    vecs[20] = mkv(idle, 32'h0, 1'b1, 32'h0, 32'h4, 1'b0);

    // Reset with redirects active: reset dominates
    rst.mp = 1'b1; rst.mpc = 32'h1234; rst.bh = 1'b1; rst.bpc = 32'h5678;
    run_cycle(rst);
    run_cycle(rst);
    chk("reset fetchValid", bus.fetchValid, 32'h0);
    chk("reset fetchPC",    bus.fetchPC,    32'h0);
    chk("reset seqPC",      bus.seqPC,      32'h0);
    chk("reset predTaken",  bus.predTaken,  32'h0);
    chk("reset rAddress",   bus.rAddress,   32'h0);

    // Directed table; rAddress is checked in the cycle before the edge
    for (int i = 0; i < 21; i++) begin
      resetN = 1'b1; bus.decodeReady = vecs[i].s.dr; bus.mispredict = vecs[i].s.mp;
      bus.jump = vecs[i].s.j; bus.btbHit = vecs[i].s.bh;
      #2;
      chk($sformatf("vec%0d rAddress", i), bus.rAddress, vecs[i].exp_raddr);
      run_cycle(vecs[i].s);
      chk($sformatf("vec%0d fetchValid", i), bus.fetchValid, 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d fetchPC", i),    bus.fetchPC,    vecs[i].exp_fpc);
      chk($sformatf("vec%0d seqPC", i),      bus.seqPC,      vecs[i].exp_spc);
      chk($sformatf("vec%0d predTaken", i),  bus.predTaken,  32'(vecs[i].exp_pred));
    end

    // Reset mid-stall with a mispredict pending: in-flight fetch discarded
    run_cycle(mks(0, 0, 0, 0, 0, 0, 0));
    rst = mks(1, 32'h700, 1, 32'h800, 1, 32'h900, 0); rst.rstn = 1'b0;
    run_cycle(rst);
    chk("midstall reset fetchValid", bus.fetchValid, 32'h0);
    chk("midstall reset fetchPC",    bus.fetchPC,    32'h0);
    resetN = 1'b1; bus.decodeReady = 1'b1; bus.mispredict = 1'b0; bus.jump = 1'b0;
    #1;
    chk("midstall reset rAddress",   bus.rAddress,   32'h0);
    run_cycle(idle);
    chk("post reset first fetchPC",  bus.fetchPC,    32'h0);
    chk("post reset first valid",    bus.fetchValid, 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) run_cycle(rand_stim());

`ifdef FETCH_PERF_EN
    chk("fetchCount",    bus.fetchCount,    m_fcnt);
    chk("redirectCount", bus.redirectCount, m_rcnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
